// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks EX/MEM/WB destinations, selects operand
// forwarding sources and raises a one-cycle stall on load-use hazards.
module hazard_scoreboard (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_rs_used,
    input  logic        id_rt_used,
    input  logic [4:0]  id_dst,
    input  logic        id_reg_write,
    input  logic        id_is_load,
    input  logic        id_flush,
    output logic        stall,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_cnt
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    logic [4:0]  ex_dst_q,  ex_dst_d;
    logic        ex_wr_q,   ex_wr_d;
    logic        ex_ld_q,   ex_ld_d;
    logic [4:0]  mem_dst_q, mem_dst_d;
    logic        mem_wr_q,  mem_wr_d;
    logic        mem_ld_q,  mem_ld_d;
    logic [4:0]  wb_dst_q,  wb_dst_d;
    logic        wb_wr_q,   wb_wr_d;
    logic        wb_ld_q,   wb_ld_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
    logic load_use;

    // An EX load hit yields no forward: its data does not exist yet.
    function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic ex_ld,
                                           input logic mem_hit, input logic wb_hit);
        logic [1:0] sel;
        sel = FWD_RF;
        if (ex_hit) begin
            sel = ex_ld ? FWD_RF : FWD_EX;
        end else if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    always_comb begin
        ex_hit_a  = ex_wr_q  && (ex_dst_q  != 5'd0) && (ex_dst_q  == id_rs) && id_rs_used;
        ex_hit_b  = ex_wr_q  && (ex_dst_q  != 5'd0) && (ex_dst_q  == id_rt) && id_rt_used;
        mem_hit_a = mem_wr_q && (mem_dst_q != 5'd0) && (mem_dst_q == id_rs) && id_rs_used;
        mem_hit_b = mem_wr_q && (mem_dst_q != 5'd0) && (mem_dst_q == id_rt) && id_rt_used;
        wb_hit_a  = wb_wr_q  && (wb_dst_q  != 5'd0) && (wb_dst_q  == id_rs) && id_rs_used;
        wb_hit_b  = wb_wr_q  && (wb_dst_q  != 5'd0) && (wb_dst_q  == id_rt) && id_rt_used;

        load_use = ex_ld_q && (ex_hit_a || ex_hit_b);
        stall    = load_use && !id_flush;
        fwd_a    = fwd_sel(ex_hit_a, ex_ld_q, mem_hit_a, wb_hit_a);
        fwd_b    = fwd_sel(ex_hit_b, ex_ld_q, mem_hit_b, wb_hit_b);
    end

    always_comb begin
        mem_dst_d = ex_dst_q;
        mem_wr_d  = ex_wr_q;
        mem_ld_d  = ex_ld_q;
        wb_dst_d  = mem_dst_q;
        wb_wr_d   = mem_wr_q;
        wb_ld_d   = mem_ld_q;
        if (stall || id_flush) begin
            ex_dst_d = 5'd0;
            ex_wr_d  = 1'b0;
            ex_ld_d  = 1'b0;
        end else begin
            ex_dst_d = id_dst;
            ex_wr_d  = id_reg_write;
            ex_ld_d  = id_is_load;
        end
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_dst_q    <= 5'd0;
            ex_wr_q     <= 1'b0;
            ex_ld_q     <= 1'b0;
            mem_dst_q   <= 5'd0;
            mem_wr_q    <= 1'b0;
            mem_ld_q    <= 1'b0;
            wb_dst_q    <= 5'd0;
            wb_wr_q     <= 1'b0;
            wb_ld_q     <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            ex_dst_q    <= ex_dst_d;
            ex_wr_q     <= ex_wr_d;
            ex_ld_q     <= ex_ld_d;
            mem_dst_q   <= mem_dst_d;
            mem_wr_q    <= mem_wr_d;
            mem_ld_q    <= mem_ld_d;
            wb_dst_q    <= wb_dst_d;
            wb_wr_q     <= wb_wr_d;
            wb_ld_q     <= wb_ld_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, hand-written reset and
// saturation sequences, then random traffic against a pipeline-history model.
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic        id_rs_used, id_rt_used, id_reg_write, id_is_load, id_flush;
    logic        stall;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rs_used   (id_rs_used),
        .id_rt_used   (id_rt_used),
        .id_dst       (id_dst),
        .id_reg_write (id_reg_write),
        .id_is_load   (id_is_load),
        .id_flush     (id_flush),
        .stall        (stall),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs, rt;
        logic        rsu, rtu;
        logic [4:0]  dst;
        logic        rw, ld, fl;
        logic        e_stall;
        logic [1:0]  e_a, e_b;
        logic [15:0] e_cnt;
    } vec_t;

    typedef struct {
        int dst;
        bit wr;
        bit ld;
    } ent_t;

    vec_t vecs[20];
    ent_t pipe[3];   // index 0 = youngest in-flight instruction (EX)
    int   cnt_m;

    function automatic vec_t mk(int rs, int rt, bit rsu, bit rtu, int dst, bit rw, bit ld,
                                bit fl, bit es, int ea, int eb, int ec);
        vec_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.rsu = rsu; v.rtu = rtu;
        v.dst = 5'(dst); v.rw = rw; v.ld = ld; v.fl = fl;
        v.e_stall = es; v.e_a = 2'(ea); v.e_b = 2'(eb); v.e_cnt = 16'(ec);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int rs, input int rt, input bit rsu, input bit rtu,
                         input int dst, input bit rw, input bit ld, input bit fl);
        id_rs = 5'(rs); id_rt = 5'(rt); id_rs_used = rsu; id_rt_used = rtu;
        id_dst = 5'(dst); id_reg_write = rw; id_is_load = ld; id_flush = fl;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        nop();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Youngest matching producer wins; a load still in EX has nothing to forward.
    function automatic int model_src(int s, bit used, output bit load_hit);
        load_hit = 1'b0;
        if (!used || s == 0) return 0;
        for (int i = 0; i < 3; i++) begin
            if (pipe[i].wr && pipe[i].dst == s) begin
                if (i == 0 && pipe[0].ld) begin
                    load_hit = 1'b1;
                    return 0;
                end
                return i + 1;
            end
        end
        return 0;
    endfunction

    initial begin
        bit ha, hb, e_stall;
        int ea, eb;

        rst = 1'b1;
        nop();
        #1;
        chk("reset_stall", stall, 0);
        chk("reset_fwd_a", fwd_a, 0);
        chk("reset_cnt", stall_cnt, 0);
        drive(5, 5, 1, 1, 5, 1, 1, 0);
        @(negedge clk);
        #1;
        chk("reset_hold_stall", stall, 0);
        chk("reset_hold_fwd_b", fwd_b, 0);
        rst = 1'b0;
        nop();
        @(negedge clk);

        //        rs rt rsu rtu dst rw ld fl  stall a  b  cnt
        vecs[0]  = mk(1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(3, 4, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        vecs[2]  = mk(3, 3, 1, 1, 0, 0, 0, 0, 0, 2, 2, 0);
        vecs[3]  = mk(3, 0, 1, 1, 0, 0, 0, 0, 0, 3, 0, 0);
        vecs[4]  = mk(1, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0);
        vecs[5]  = mk(6, 5, 1, 1, 8, 1, 0, 0, 1, 0, 0, 0);
        vecs[6]  = mk(6, 5, 1, 1, 8, 1, 0, 0, 0, 0, 2, 1);
        vecs[7]  = mk(0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1);
        vecs[8]  = mk(0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1);
        vecs[9]  = mk(0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1);
        vecs[10] = mk(7, 7, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1);
        vecs[11] = mk(7, 7, 1, 1, 0, 0, 0, 0, 0, 2, 2, 1);
        vecs[12] = mk(7, 7, 1, 1, 0, 1, 0, 0, 0, 3, 3, 1);
        vecs[13] = mk(0, 0, 1, 1, 9, 1, 0, 0, 0, 0, 0, 1);
        vecs[14] = mk(0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[15] = mk(9, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[16] = mk(0, 0, 0, 0, 12, 1, 1, 0, 0, 0, 0, 1);
        vecs[17] = mk(12, 0, 1, 0, 13, 1, 0, 1, 0, 0, 0, 1);
        vecs[18] = mk(13, 12, 1, 1, 0, 0, 0, 0, 0, 0, 2, 1);
        vecs[19] = mk(13, 12, 1, 1, 0, 0, 0, 0, 0, 0, 3, 1);

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].rs, vecs[i].rt, vecs[i].rsu, vecs[i].rtu,
                  vecs[i].dst, vecs[i].rw, vecs[i].ld, vecs[i].fl);
            #1;
            chk($sformatf("vec%0d_stall", i), stall, vecs[i].e_stall);
            chk($sformatf("vec%0d_fwd_a", i), fwd_a, vecs[i].e_a);
            chk($sformatf("vec%0d_fwd_b", i), fwd_b, vecs[i].e_b);
            chk($sformatf("vec%0d_cnt", i), stall_cnt, vecs[i].e_cnt);
            @(negedge clk);
        end

        // Three load-use stalls, then async reset in the middle of a fourth.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 5, 1, 1, 0);
            @(negedge clk);
            drive(0, 5, 0, 1, 0, 0, 0, 0);
            @(negedge clk);
            nop();
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 5, 1, 1, 0);
        @(negedge clk);
        drive(5, 5, 1, 1, 0, 0, 0, 0);
        #1;
        chk("midrst_pre_stall", stall, 1);
        chk("midrst_pre_cnt", stall_cnt, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_stall", stall, 0);
        chk("midrst_fwd_a", fwd_a, 0);
        chk("midrst_fwd_b", fwd_b, 0);
        chk("midrst_cnt", stall_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 5, 1, 1, 0);
        @(negedge clk);
        drive(0, 5, 0, 1, 0, 0, 0, 0);
        #1;
        chk("post_rst_stall", stall, 1);
        chk("post_rst_fwd_b", fwd_b, 0);
        @(negedge clk);
        nop();
        #1;
        chk("post_rst_cnt", stall_cnt, 1);
        @(negedge clk);

        // Saturation from a preloaded count.
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        chk("sat_preload", stall_cnt, 16'hFFFE);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 6, 1, 1, 0);
            @(negedge clk);
            drive(6, 0, 1, 0, 0, 0, 0, 0);
            #1;
            chk($sformatf("sat_stall%0d", k), stall, 1);
            @(negedge clk);
            nop();
            #1;
            chk($sformatf("sat_cnt%0d", k), stall_cnt, 16'hFFFF);
            @(negedge clk);
        end

        // Random traffic against the pipeline-history model.
        do_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 1'b0, 1'b0};
        cnt_m = 0;
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 7), $urandom_range(0, 7),
                  ($urandom % 4) != 0, ($urandom % 4) != 0,
                  $urandom_range(0, 7), ($urandom % 4) != 0,
                  ($urandom % 3) == 0, ($urandom % 8) == 0);
            #1;
            ea = model_src(int'(id_rs), id_rs_used, ha);
            eb = model_src(int'(id_rt), id_rt_used, hb);
            e_stall = (ha || hb) && !id_flush;
            chk("rnd_stall", stall, e_stall);
            chk("rnd_fwd_a", fwd_a, ea);
            chk("rnd_fwd_b", fwd_b, eb);
            chk("rnd_cnt", stall_cnt, cnt_m);
            @(posedge clk);
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (e_stall || id_flush) pipe[0] = '{0, 1'b0, 1'b0};
            else pipe[0] = '{int'(id_dst), id_reg_write, id_is_load};
            if (e_stall && cnt_m < 65535) cnt_m++;
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have one clock and its reset SHALL be asynchronous and active-high; ports SHALL be named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 id_rs  input  5  source register A of the instruction in ID.
REQ-005 id_rt  input  5  source register B of the instruction in ID.
REQ-006 id_rs_used  input  1  ID instruction reads id_rs.
REQ-007 id_rt_used  input  1  ID instruction reads id_rt.
REQ-008 id_dst  input  5  destination register of the ID instruction, after the rt/rd destination select.
REQ-009 id_reg_write  input  1  ID instruction writes id_dst.
REQ-010 id_is_load  input  1  ID instruction is a load; its data is valid only at the MEM stage output.
REQ-011 id_flush  input  1  squash the ID instruction because of a taken branch or jump.
REQ-012 stall  output  1  hold PC and IF/ID; insert a bubble into EX.
REQ-013 fwd_a  output  2  operand A source: 00 = register file, 01 = EX ALU result, 10 = MEM result, 11 = WB result.
REQ-014 fwd_b  output  2  operand B source, same encoding as fwd_a.
REQ-015 stall_cnt  output  16  count of cycles in which stall was asserted.

Function
REQ-016 The block SHALL hold three tracking entries (EX, MEM, WB); each entry holds dst[4:0], wr (write valid) and ld (load).
REQ-017 On each rising clk edge with no stall and no id_flush, EX SHALL take {id_dst, id_reg_write, id_is_load}, MEM SHALL take EX, and WB SHALL take MEM.
REQ-018 When stall=1 or id_flush=1, EX SHALL take a bubble {0,0,0}, while MEM and WB SHALL still advance.
REQ-019 An entry SHALL match source s only when wr=1, dst!=0, dst==s, and the matching used flag is 1.
REQ-020 Register 0 SHALL never match, stall, or forward.
REQ-021 stall SHALL be combinational and SHALL equal 1 when the EX entry has ld=1 and matches id_rs or id_rt; otherwise it SHALL equal 0.
REQ-022 When id_flush=1, stall SHALL be 0, because the flush overrides the hazard.
REQ-023 A load-use hazard SHALL produce exactly one stall cycle; on the next cycle the load sits in MEM and the operand SHALL forward with code 10.
REQ-024 fwd_a and fwd_b SHALL be combinational and SHALL use priority EX (01) > MEM (10) > WB (11) > register file (00).
REQ-025 The newest producer SHALL win when several stages match the same source.
REQ-026 A matching EX entry with ld=1 SHALL NOT produce code 01; it asserts stall instead, and fwd SHALL then equal 00.
REQ-027 fwd_a and fwd_b SHALL be evaluated independently; id_rs==id_rt SHALL give identical codes on both outputs.
REQ-028 stall_cnt SHALL increment by 1 on each clk edge where stall=1, and SHALL saturate at 16'hFFFF without wrapping.
REQ-029 Block latency SHALL be 0 cycles from ID inputs to stall/fwd; tracking state SHALL update 1 cycle after the inputs are sampled.
REQ-030 Simultaneous stall-condition and id_flush SHALL behave as flush only: EX bubble, stall=0, stall_cnt unchanged.

Reset
REQ-031 While rst=1, all entries SHALL be {0,0,0}, stall_cnt SHALL be 0, and stall, fwd_a and fwd_b SHALL be 0 for any input.
REQ-032 Reset asserted mid-stall SHALL clear state immediately, with no clock edge required.
REQ-033 After rst deasserts, the first clk edge SHALL load EX normally.

Verification
REQ-034 Scenario: ALU back-to-back. add $3 (dst=3, wr=1) then ID rs=3 used -> fwd_a=01, stall=0.
REQ-035 Scenario: load-use. lw $5 (ld=1), then ID rt=5 used -> stall=1 for exactly one cycle, then fwd_b=10, stall_cnt=1.
REQ-036 Scenario: priority. Writes to $7 in WB, MEM and EX, with ID rs=rt=7 -> fwd_a=fwd_b=01.
REQ-037 Scenario: $0 and unused operands. dst=0 writer followed by rs=0, and rt=9 with id_rt_used=0 after a $9 writer -> fwd=00, stall=0.
REQ-038 Scenario: flush during load-use. id_flush=1 while stall condition is true -> stall=0, next-cycle EX entry wr=0, stall_cnt unchanged.
REQ-039 Scenario: reset mid-operation. rst pulsed asynchronously while stall=1 and stall_cnt=3 -> stall=0, fwd=00, stall_cnt=0 immediately; counter saturation checked separately by preloading 16'hFFFE and forcing 3 stall cycles -> 16'hFFFF.
